// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback over a shared datapath.
// Optional performance counters are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [3:0]  state
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        EXEC_I    = 4'd10,
        I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       waiting;
    logic       op_legal;

    // zero only qualifies PCWriteCond inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

    assign waiting = ((state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE))
                     && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter restarts per state and saturates, so the timeout flag cannot be missed by wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_cnt <= 8'd0;
            end else if (waiting && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (waiting && (({1'b0, wait_cnt} + 9'd1) >= 9'(FETCH_TIMEOUT))) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = EXEC_I;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR:  state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: begin
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WRITE: begin
                if (mem_ready) state_d = FETCH;
            end
            EXEC_R:    state_d = R_WB;
            EXEC_I:    state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !op_legal;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEM_READ: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    IorD    = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                I_WB: begin
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = reset ? 4'd0 : state_q;
    assign mem_timeout = timeout_q & ~reset;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        retire;

    // An instruction retires when a completing state hands back to FETCH; illegal decodes never retire
    assign retire = (state_d == FETCH) &&
                    ((state_q == MEM_WB) || (state_q == R_WB) || (state_q == I_WB) ||
                     (state_q == BRANCH) || (state_q == JUMP) || (state_q == MEM_WRITE));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_count = reset ? 32'd0 : cycle_q;
    assign instr_count = reset ? 32'd0 : instr_q;
`endif

endmodule
